// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the core memory stage and the data memory.
// Issues one access at a time, aligns store lanes, extends load results, checks alignment and timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_load,
  input  logic        start_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] rdata,
  output logic        mem_request,
  output logic        mem_we_re,
  output logic        mem_load,
  output logic [3:0]  mem_mask,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic        mem_valid,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  f3_r, f3_s;
  logic [1:0]  off_r, off_s;
  logic        is_store_r, is_store_s;
  logic        err_s;
  logic [31:0] rdata_s, data_s;
  logic [3:0]  mask_s;
  logic [7:0]  address_s;
  logic        cmd_err_s, legal_s, misal_s;
  logic [3:0]  new_mask_s;
  logic [31:0] new_data_s;
  logic        unused_addr_s;

  // Address bits above the 256-word window are deliberately dropped.
  assign unused_addr_s = ^addr[31:10];

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Command decode: legality, alignment and lane placement of the incoming request.
  always_comb begin
    legal_s    = 1'b0;
    misal_s    = 1'b0;
    new_mask_s = 4'b0000;
    new_data_s = 32'd0;
    if (start_store) begin
      legal_s = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_s = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b00: begin
        new_mask_s = 4'b0001 << addr[1:0];
        new_data_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        misal_s    = addr[0];
        new_mask_s = addr[1] ? 4'b1100 : 4'b0011;
        new_data_s = {2{store_data[15:0]}};
      end
      2'b10: begin
        misal_s    = (addr[1:0] != 2'b00);
        new_mask_s = 4'b1111;
        new_data_s = store_data;
      end
      default: begin
        misal_s    = 1'b0;
        new_mask_s = 4'b0000;
        new_data_s = 32'd0;
      end
    endcase
    cmd_err_s = (start_load && start_store) || !legal_s || misal_s;
  end

  // Next-state and next-output computation.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    f3_s       = f3_r;
    off_s      = off_r;
    is_store_s = is_store_r;
    err_s      = 1'b0;
    rdata_s    = rdata;
    mask_s     = mem_mask;
    address_s  = mem_address;
    data_s     = mem_data_in;
    case (state_r)
      IDLE: begin
        if (start_load || start_store) begin
          if (cmd_err_s) begin
            state_s = RESP;
            err_s   = 1'b1;
            rdata_s = 32'd0;
          end else begin
            state_s    = REQ;
            f3_s       = funct3;
            off_s      = addr[1:0];
            is_store_s = start_store;
            address_s  = addr[9:2];
            mask_s     = new_mask_s;
            data_s     = new_data_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (is_store_r) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
          cnt_s   = 8'd0;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          state_s = RESP;
          rdata_s = extract(f3_r, off_r, mem_data_out);
        end else if (cnt_r == 8'(TIMEOUT - 1)) begin
          state_s = RESP;
          err_s   = 1'b1;
          rdata_s = 32'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, context and registered outputs; outputs reflect the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      f3_r        <= 3'd0;
      off_r       <= 2'd0;
      is_store_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      rdata       <= 32'd0;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_load    <= 1'b0;
      mem_mask    <= 4'd0;
      mem_address <= 8'd0;
      mem_data_in <= 32'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      f3_r        <= f3_s;
      off_r       <= off_s;
      is_store_r  <= is_store_s;
      busy        <= (state_s != IDLE);
      done        <= (state_s == RESP);
      error       <= (state_s == RESP) && err_s;
      rdata       <= rdata_s;
      mem_request <= (state_s == REQ);
      mem_we_re   <= (state_s == REQ) && is_store_s;
      mem_load    <= (state_s == REQ) && !is_store_s;
      mem_mask    <= mask_s;
      mem_address <= address_s;
      mem_data_in <= data_s;
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store initiator that sits between the core's memory stage and the data memory top. Accepts one load or store command at a time from the core, drives the data-memory request interface (request, we_re, load, mask, word address, lane-aligned write data), waits for the memory's registered `valid` on loads, and returns a sign- or zero-extended result. It checks alignment and legal funct3 codes, and applies a response timeout.

## Interface
Parameters:
- TIMEOUT, 15, max cycles spent in WAIT before the load is aborted with error; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start_load  in  1  core command pulse: load
- start_store  in  1  core command pulse: store
- funct3  in  3  RV32I width/sign code
- addr  in  32  byte address
- store_data  in  32  store source register value
- busy  out  1  high while state != IDLE; core stalls on it
- done  out  1  one-cycle completion pulse
- error  out  1  qualifies done: misaligned, illegal, or timeout
- rdata  out  32  extended load result, valid with done
- mem_request  out  1  memory access strobe
- mem_we_re  out  1  1 = write, 0 = read
- mem_load  out  1  read-response request to memory
- mem_mask  out  4  byte-lane enables
- mem_address  out  8  word address = addr[9:2]
- mem_data_in  out  32  lane-aligned write data
- mem_valid  in  1  memory read response valid
- mem_data_out  in  32  memory read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. All outputs are registered.
- Commands are accepted only in IDLE. Starts seen in any other state are ignored.
- On acceptance, the block latches funct3, addr[1:0], addr[9:2] and the aligned data/mask.
- Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Error path: start_load and start_store both high, an illegal code, or a misaligned address -> no memory access; go to RESP with error=1 and rdata=0.
- addr[31:10] is ignored; the address wraps inside the 256-word memory.
- Mask and lane data, with off = addr[1:0]:
  - byte: mask = 1<<off, data = {4{sd[7:0]}}
  - half: mask = 0011 (off=0) or 1100 (off=2), data = {2{sd[15:0]}}
  - word: mask = 1111, data = sd
  - The same mask is driven on loads.
- Load extraction: select the byte or half at off from mem_data_out, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- Transitions:
  - IDLE -> REQ on a legal start; IDLE -> RESP on an erroneous start.
  - REQ -> RESP for a store; REQ -> WAIT for a load.
  - WAIT -> RESP when mem_valid=1 (capture rdata), or when the wait counter reaches TIMEOUT (error=1, rdata=0).
  - RESP -> IDLE unconditionally.
- mem_valid outside WAIT is ignored.

## Timing
- Reset (async, active-low) values:
  - state IDLE, wait counter 0
  - busy, done, error, mem_request, mem_we_re, mem_load = 0
  - mem_mask, mem_address, mem_data_in, rdata = 0
- Reset mid-transaction aborts it immediately; no done is produced.
- Cycle 0: start sampled in IDLE.
- Cycle 1 (REQ):
  - mem_request=1 for exactly this one cycle.
  - Store: mem_we_re=1, mem_load=0.
  - Load: mem_we_re=0, mem_load=1.
  - mem_address, mem_mask and mem_data_in are stable.
- Memory raises mem_valid in the cycle after mem_load, so a nominal load sees mem_valid in cycle 2 (WAIT).
- Latency, start to done:
  - store: 2 cycles (done in cycle 2)
  - nominal load: 3 cycles (done in cycle 3)
  - error: 1 cycle
  - timeout: TIMEOUT+2 cycles
- The wait counter is cleared on entry to WAIT and increments each WAIT cycle without mem_valid.
- done is high for exactly one cycle, in RESP. rdata holds its value until the next done.
- busy is high from cycle 1 through the RESP cycle inclusive. A new start is accepted in the cycle after RESP.

## Test plan
- SW addr=0x0000_0014, store_data=0xDEADBEEF:
  - cycle 1: mem_request=1, mem_we_re=1, mem_address=0x05, mem_mask=1111, mem_data_in=0xDEADBEEF
  - cycle 2: done=1, error=0
- SB addr=0x...0003, store_data=0x12345678 -> mem_mask=1000, mem_data_in=0x78787878. SH at off 2 -> mem_mask=1100, mem_data_in=0x56785678.
- Memory word 0x80FF7F01 at word 5:
  - LB addr 0x15 -> rdata 0x0000007F
  - LB addr 0x16 -> rdata 0xFFFFFFFF
  - LBU addr 0x16 -> rdata 0x000000FF
  - LH addr 0x16 -> rdata 0xFFFF80FF
  - LW -> rdata 0x80FF7F01
  - done in cycle 3 for each
- Error starts (LW addr 0x02, funct3=011, both starts high) -> no mem_request; done=1 and error=1 in cycle 1; rdata=0.
- Load with mem_valid held low, TIMEOUT=15 -> done=1, error=1 at cycle 17, then a return to IDLE. A subsequent SW completes normally.
- Robustness:
  - rst low during WAIT -> all outputs 0 asynchronously, no done.
  - start_store pulsed while busy -> ignored; only one mem_request is seen.
